// File: rtl/result_bcd_converter_if.sv
//------------------------------------------------------------------------------
// Module : result_bcd_converter_if
// Brief  : Request/result bundle for the signed-binary to BCD converter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface result_bcd_converter_if;
    logic       start;
    logic [8:0] res;
    logic       sign;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
    logic       busy;
    logic       done;

    modport master (
        output start, res,
        input  sign, hundreds, tens, units, busy, done
    );

    modport slave (
        input  start, res,
        output sign, hundreds, tens, units, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/result_bcd_converter.sv
//------------------------------------------------------------------------------
// Module : result_bcd_converter
// Brief  : Converts a 9-bit two's-complement result into sign + 3 BCD digits
//          by double-dabble, fixed 10-cycle latency from start to done.
//          Option: LEADING_ZERO_BLANK_EN blanks leading zero digits as 4'hF.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module result_bcd_converter (
    input  wire                         relogio,
    input  wire                         reset,
    result_bcd_converter_if.slave       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] C_LAST_SHIFT = 4'd8;
    localparam logic [3:0] C_BLANK      = 4'hF;

    state_t      state_q, state_d;
    logic [8:0]  mag_q, mag_d;
    logic [11:0] bcd_q, bcd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        sign_q, sign_d;
    logic [3:0]  hund_q, hund_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  units_q, units_d;
    logic        done_q, done_d;

    logic [8:0]  w_abs;
    logic [11:0] w_adj;

    // Negating 9'h100 wraps back to 9'h100, which read unsigned is 256.
    assign w_abs = bus.res[8] ? (~bus.res + 9'd1) : bus.res;

    always_comb begin
        w_adj[3:0]  = (bcd_q[3:0]  >= 4'd5) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
        w_adj[7:4]  = (bcd_q[7:4]  >= 4'd5) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
        w_adj[11:8] = (bcd_q[11:8] >= 4'd5) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
    end

    always_ff @(posedge relogio) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mag_q   <= 9'd0;
            bcd_q   <= 12'd0;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
            sign_q  <= 1'b0;
            hund_q  <= 4'd0;
            tens_q  <= 4'd0;
            units_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sign_q  <= sign_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sign_d  = sign_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    neg_d   = bus.res[8];
                    mag_d   = w_abs;
                    bcd_d   = 12'd0;
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, mag_d} = {w_adj[10:0], mag_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == C_LAST_SHIFT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                sign_d  = neg_q;
                units_d = bcd_q[3:0];
`ifdef LEADING_ZERO_BLANK_EN
                hund_d  = (bcd_q[11:8] == 4'd0) ? C_BLANK : bcd_q[11:8];
                tens_d  = (bcd_q[11:4] == 8'd0) ? C_BLANK : bcd_q[7:4];
`else
                hund_d  = bcd_q[11:8];
                tens_d  = bcd_q[7:4];
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.sign     = sign_q;
    assign bus.hundreds = hund_q;
    assign bus.tens     = tens_q;
    assign bus.units    = units_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_result_bcd_converter.sv
//------------------------------------------------------------------------------
// Module : tb_result_bcd_converter
// Brief  : Directed, table-driven bench for result_bcd_converter.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_result_bcd_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_bcd_converter_if bus();

    result_bcd_converter dut (
        .relogio (clk),
        .reset   (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [8:0] res;
        logic       sgn;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
    } vec_t;

    int errors   = 0;
    int checks   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_h(input logic [3:0] h);
`ifdef LEADING_ZERO_BLANK_EN
        return (h == 4'd0) ? 4'hF : h;
`else
        return h;
`endif
    endfunction

    function automatic logic [3:0] exp_t(input logic [3:0] h, input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
        return (h == 4'd0 && t == 4'd0) ? 4'hF : t;
`else
        return t;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
        cyc++;
    endtask

    task automatic check_digits(input string tag, input logic s,
                                input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        check({tag, ".sign"},     int'(bus.sign),     int'(s));
        check({tag, ".hundreds"}, int'(bus.hundreds), int'(exp_h(h)));
        check({tag, ".tens"},     int'(bus.tens),     int'(exp_t(h, t)));
        check({tag, ".units"},    int'(bus.units),    int'(u));
    endtask

    task automatic run_conv(input string tag, input vec_t v);
        bus.res   = v.res;
        bus.start = 1'b1;
        busy_cnt  = 0;
        done_cnt  = 0;
        tick();
        bus.start = 1'b0;
        bus.res   = ~v.res;
        repeat (9) tick();
        check({tag, ".busy_cycles"}, busy_cnt, 10);
        check({tag, ".early_done"},  done_cnt, 0);
        tick();
        check({tag, ".done"}, int'(bus.done), 1);
        check({tag, ".busy_end"}, int'(bus.busy), 0);
        check_digits(tag, v.sgn, v.h, v.t, v.u);
        repeat (3) tick();
        check({tag, ".done_once"}, done_cnt, 1);
        check_digits({tag, ".hold"}, v.sgn, v.h, v.t, v.u);
    endtask

    task automatic wait_done(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done) begin
                c  = cyc;
                ok = 1'b1;
                return;
            end
        end
    endtask

    vec_t vecs [9];

    initial begin
        int  c1, c2;
        bit  ok1, ok2;
        vec_t v;

        vecs[0] = '{9'h000, 1'b0, 4'd0, 4'd0, 4'd0};
        vecs[1] = '{9'h1FF, 1'b1, 4'd0, 4'd0, 4'd1};
        vecs[2] = '{9'h0FF, 1'b0, 4'd2, 4'd5, 4'd5};
        vecs[3] = '{9'h100, 1'b1, 4'd2, 4'd5, 4'd6};
        vecs[4] = '{9'h19C, 1'b1, 4'd1, 4'd0, 4'd0};
        vecs[5] = '{9'h07B, 1'b0, 4'd1, 4'd2, 4'd3};
        vecs[6] = '{9'h00A, 1'b0, 4'd0, 4'd1, 4'd0};
        vecs[7] = '{9'h064, 1'b0, 4'd1, 4'd0, 4'd0};
        vecs[8] = '{9'h1F6, 1'b1, 4'd0, 4'd1, 4'd0};

        bus.start = 1'b0;
        bus.res   = 9'h000;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset.busy", int'(bus.busy), 0);
        check("reset.done", int'(bus.done), 0);
        check("reset.sign", int'(bus.sign), 0);
        check("reset.hundreds", int'(bus.hundreds), 0);
        check("reset.tens", int'(bus.tens), 0);
        check("reset.units", int'(bus.units), 0);

        for (int i = 0; i < 9; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i]);
        end

        // Second start mid-conversion must be ignored.
        bus.res   = 9'h07B;
        bus.start = 1'b1;
        busy_cnt  = 0;
        done_cnt  = 0;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.res   = 9'h001;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.res   = 9'h1FF;
        repeat (5) tick();
        tick();
        check("ignore.done", int'(bus.done), 1);
        check_digits("ignore", 1'b0, 4'd1, 4'd2, 4'd3);
        repeat (12) tick();
        check("ignore.busy_cycles", busy_cnt, 10);
        check("ignore.done_count", done_cnt, 1);

        // Reset in flight discards the conversion and clears outputs.
        bus.res   = 9'h0FF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", int'(bus.busy), 0);
        check("abort.done", int'(bus.done), 0);
        check("abort.sign", int'(bus.sign), 0);
        check("abort.hundreds", int'(bus.hundreds), 0);
        check("abort.tens", int'(bus.tens), 0);
        check("abort.units", int'(bus.units), 0);
        busy_cnt = 0;
        done_cnt = 0;
        repeat (12) tick();
        check("abort.no_done", done_cnt, 0);
        check("abort.no_busy", busy_cnt, 0);
        v = '{9'h02A, 1'b0, 4'd0, 4'd4, 4'd2};
        run_conv("after_abort", v);

        // Reset wins over a simultaneous start.
        bus.res   = 9'h0FF;
        bus.start = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_prio.busy", int'(bus.busy), 0);
        check("rst_prio.units", int'(bus.units), 0);
        tick();
        check("rst_prio.busy2", int'(bus.busy), 0);

        // Held start re-triggers every 11 cycles.
        bus.res   = 9'h009;
        bus.start = 1'b1;
        wait_done(c1, ok1);
        check("held.first_done", int'(ok1), 1);
        check_digits("held1", 1'b0, 4'd0, 4'd0, 4'd9);
        wait_done(c2, ok2);
        check("held.second_done", int'(ok2), 1);
        check("held.period", c2 - c1, 11);
        check_digits("held2", 1'b0, 4'd0, 4'd0, 4'd9);
        bus.start = 1'b0;
        repeat (12) tick();
        check("held.idle", int'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
